// File: rtl/score_display_ctrl_if.sv
// Bus between a score source and the score display controller: conversion
// handshake, BCD digit outputs and per-digit decoder enables.
interface score_display_ctrl_if;
  logic [7:0] score;
  logic       load;
  logic       blink_en;
  logic       ready;
  logic       done;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [2:0] dig_en;

  modport master (
    output score, load, blink_en,
    input  ready, done, digit0, digit1, digit2, dig_en
  );

  modport slave (
    input  score, load, blink_en,
    output ready, done, digit0, digit1, digit2, dig_en
  );
endinterface

// File: rtl/score_display_ctrl.sv
// Binary-to-BCD score converter (sequential double dabble) driving three
// digit decoders, with leading-zero blanking and an independent blink timer.
module score_display_ctrl #(
  parameter int BLINK_HALF = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  score_display_ctrl_if.slave  bus
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [11:0]     digits_q, digits_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;

  logic [11:0]     bcd_adj_s;
  logic [11:0]     bcd_next_s;
  logic [7:0]      sr_next_s;
  logic [2:0]      base_en_s;

  // Add-3 correction on each nibble, then one left shift of {bcd, sr}.
  always_comb begin
    bcd_adj_s = 12'd0;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
    bcd_next_s = {bcd_adj_s[10:0], sr_q[7]};
    sr_next_s  = {sr_q[6:0], 1'b0};
  end

  // Conversion state machine next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.load) begin
          sr_d    = bus.score;
          bcd_d   = 12'd0;
          cnt_d   = 3'd0;
          ready_d = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        ready_d = 1'b0;
        bcd_d   = bcd_next_s;
        sr_d    = sr_next_s;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          digits_d = bcd_next_s;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = SHIFT;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Blink timer: held at zero while disabled, otherwise free-running.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!bus.blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == CW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sr_q        <= 8'd0;
      bcd_q       <= 12'd0;
      cnt_q       <= 3'd0;
      digits_q    <= 12'd0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Leading-zero blanking: ones digit always lit.
  assign base_en_s = {(digits_q[11:8] != 4'd0),
                      (digits_q[11:8] != 4'd0) || (digits_q[7:4] != 4'd0),
                      1'b1};

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.digit0 = digits_q[3:0];
  assign bus.digit1 = digits_q[7:4];
  assign bus.digit2 = digits_q[11:8];
  assign bus.dig_en = phase_q ? 3'b000 : base_en_s;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: stimulus pushes expected digits,
// a negedge monitor pops and compares on every done pulse.
module tb_score_display_ctrl;

  logic clk;
  logic reset;
  score_display_ctrl_if bus ();

  score_display_ctrl #(.BLINK_HALF(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] digits;
    logic [2:0]  en;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input int s);
    exp_t e;
    int d2, d1, d0;
    d2 = s / 100;
    d1 = (s / 10) % 10;
    d0 = s % 10;
    e.digits = {d2[3:0], d1[3:0], d0[3:0]};
    e.en     = {(d2 != 0), (d2 != 0) || (d1 != 0), 1'b1};
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("digits", int'({bus.digit2, bus.digit1, bus.digit0}), int'(e.digits));
        if (!bus.blink_en) chk("dig_en", int'(bus.dig_en), int'(e.en));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 0, 1);
  endtask

  // One conversion with handshake timing checks; returns at a negedge.
  task automatic run_conv(input logic [7:0] s, input logic [11:0] d, input logic [2:0] en);
    exp_t e;
    e.digits = d;
    e.en     = en;
    wait_ready();
    exp_q.push_back(e);
    bus.score = s;
    bus.load  = 1'b1;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
    bus.score = ~s;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("ready_timing", int'(bus.ready), (k <= 9) ? 0 : 1);
      chk("done_timing", int'(bus.done), (k == 9) ? 1 : 0);
    end
  endtask

  initial begin
    int base;
    exp_t m;
    reset        = 1'b0;
    bus.score    = 8'd55;
    bus.load     = 1'b1;
    bus.blink_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_digits", int'({bus.digit2, bus.digit1, bus.digit0}), 0);
    chk("rst_dig_en", int'(bus.dig_en), 3'b001);
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.blink_en = 1'b0;

    run_conv(8'd255, 12'h255, 3'b111);
    run_conv(8'd40,  12'h040, 3'b011);
    run_conv(8'd7,   12'h007, 3'b001);
    run_conv(8'd0,   12'h000, 3'b001);

    // Loads during SHIFT and at the DONE-entry edge must be ignored.
    m.digits = 12'h100;
    m.en     = 3'b111;
    wait_ready();
    exp_q.push_back(m);
    base      = done_seen;
    bus.score = 8'd100;
    bus.load  = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    bus.score = 8'd99;
    repeat (2) @(posedge clk);
    #1 bus.load = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.load = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (6) @(negedge clk);
    chk("single_done", done_seen, base + 1);
    chk("ignored_load_idle", int'(bus.ready), 1);

    // Reset at E0+4 aborts the conversion.
    wait_ready();
    base      = done_seen;
    bus.score = 8'd200;
    bus.load  = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(bus.ready), 1);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_digits", int'({bus.digit2, bus.digit1, bus.digit0}), 0);
    chk("abort_dig_en", int'(bus.dig_en), 3'b001);
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_seen, base);
    run_conv(8'd13, 12'h013, 3'b011);

    // Blink with BLINK_HALF=4, then drop blink_en inside a dark phase.
    run_conv(8'd255, 12'h255, 3'b111);
    @(posedge clk);
    #1 bus.blink_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("blink_phase", int'(bus.dig_en), ((i / 4) % 2 == 1) ? 3'b000 : 3'b111);
    end
    bus.blink_en = 1'b0;
    @(negedge clk);
    chk("blink_restore", int'(bus.dig_en), 3'b111);

    for (int s = 0; s < 256; s++) begin
      m = model(s);
      run_conv(s[7:0], m.digits, m.en);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: `clk` is the single clock, and `reset` is a synchronous, active-low reset sampled on the rising edge of `clk`.
REQ-002 The block SHALL have one parameter: BLINK_HALF, default 25000000, the number of clk cycles per blink half-period (minimum 1).
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-low reset
- score  in  8  unsigned binary value to display, 0..255
- load  in  1  conversion request
- blink_en  in  1  enables display blinking
- ready  out  1  high when a load will be accepted
- done  out  1  one-cycle pulse when new digits are valid
- digit0  out  4  BCD ones, to the ones-digit decoder `binary` input
- digit1  out  4  BCD tens, to the tens-digit decoder `binary` input
- digit2  out  4  BCD hundreds, to the hundreds-digit decoder `binary` input
- dig_en  out  3  per-digit decoder `enable`; bit i drives digit i

Function
REQ-004 The block SHALL implement a state machine with three states.
- IDLE: ready=1, done=0.
- SHIFT: ready=0, done=0.
- DONE: ready=0, done=1.
REQ-005 In IDLE, a rising edge with load=1 SHALL be the acceptance edge E0. At E0 the block captures score into an 8-bit shift register, clears a 12-bit BCD accumulator and its bit counter, and enters SHIFT.
REQ-006 In SHIFT, on each edge the block SHALL:
- add 3 to every BCD nibble whose value is 5 or more;
- then shift {BCD, shift register} left by one bit, bringing in the score MSB first;
- increment the counter.
REQ-007 SHIFT SHALL perform exactly 8 iterations, on edges E0+1 through E0+8.
REQ-008 At edge E0+8, the block SHALL load digit2/digit1/digit0 from the final BCD accumulator and enter DONE.
REQ-009 As a result, done SHALL be high for exactly the one cycle after edge E0+8.
REQ-010 At edge E0+9, the block SHALL return from DONE to IDLE, so ready=1 from E0+9 onward.
REQ-011 load SHALL be ignored while in SHIFT or DONE; there is no queuing, and score changes during a conversion have no effect.
REQ-012 digit0..digit2 SHALL hold their previous values throughout SHIFT; they change only at the DONE entry edge.
REQ-013 Conversion results SHALL satisfy:
- every nibble is 0..9;
- digit2 is 0..2;
- 100*digit2 + 10*digit1 + digit0 equals the captured score.
REQ-014 Leading-zero blanking SHALL be combinational from the digit registers:
- base_en[0] = 1;
- base_en[1] = (digit2 != 0) or (digit1 != 0);
- base_en[2] = (digit2 != 0).
REQ-015 Blink timer behaviour:
- When blink_en=0, the blink counter and blink phase SHALL be held at 0.
- When blink_en=1, the counter increments each cycle.
- When the counter reaches BLINK_HALF-1, it wraps to 0 and the phase toggles.
REQ-016 dig_en SHALL equal base_en when the phase is 0, and 3'b000 when the phase is 1.
REQ-017 Deasserting blink_en SHALL restore base_en on the next edge, whatever the phase.
REQ-018 Blinking and conversion SHALL be independent; a conversion does not reset the blink timer.

Reset
REQ-019 On an edge with reset=0, the block SHALL set:
- state to IDLE;
- digit0, digit1 and digit2 to 0;
- done to 0;
- the BCD accumulator, shift register, bit counter, blink counter and blink phase to 0.
REQ-020 From the cycle after that reset edge, outputs SHALL be ready=1 and dig_en=3'b001.
REQ-021 Reset SHALL take priority over load and blink_en on the same edge.
REQ-022 Reset during SHIFT or DONE SHALL abort the conversion: no done pulse, and digits return to 0.
REQ-023 The first load accepted after reset SHALL be processed normally.

Verification
REQ-024 Load score=255 in IDLE. Required: ready=0 for 9 cycles, done=1 only in the cycle after E0+8, digits 2/5/5, dig_en=111.
REQ-025 Load score=40, then score=7, then score=0. Required:
- score=40: digits 0/4/0, dig_en=011;
- score=7: digits 0/0/7, dig_en=001;
- score=0: digits 0/0/0, dig_en=001.
REQ-026 Load score=100, then pulse load with score=99 at E0+3 and at E0+8. Required: both extra loads ignored, result 1/0/0, exactly one done pulse.
REQ-027 Apply reset at E0+4 of a score=200 conversion. Required: no done, digits 0/0/0, ready=1 after the reset edge; a following load of 13 gives 0/1/3.
REQ-028 With BLINK_HALF=4, display 255 and raise blink_en. Required: dig_en alternates 111 for 4 cycles and 000 for 4 cycles; blink_en=0 during a 000 phase restores 111 on the next edge.
REQ-029 Over an exhaustive sweep of score 0..255, a bench model SHALL confirm the digits and dig_en for every value against REQ-013 and REQ-014.
